// File: rtl/spi8_pkg.sv
// Shared constants and state encoding for the 8-lane SPI block receiver.
package spi8_pkg;

    localparam int SPI_LANES   = 8;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = SPI_LANES * BLOCK_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous control line, with edge
// detection between the last two synchronized samples.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES:0] chain;
    logic [SYNC_STAGES:0] fill;

    // fill marks when both compared samples come from the real input rather
    // than the reset preset, so a line already active after reset is not
    // mistaken for a fresh edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= {(SYNC_STAGES + 1){IDLE_LEVEL}};
            fill  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], async_in};
            fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = fill[SYNC_STAGES] &  chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
    assign fall  = fill[SYNC_STAGES] & ~chain[SYNC_STAGES-1] &  chain[SYNC_STAGES];

endmodule

// File: rtl/spi_rx_8lane.sv
// 8-lane SPI slave receiver: one byte per spi_clk rising edge, 16 bytes
// assembled MSB-first into a 128-bit block for the AES decryption engine.
module spi_rx_8lane #(
    parameter int SYNC_STAGES = 2,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       spi_clk_in,
    input  logic                       spi_cs_n_in,
    input  logic [7:0]                 spi_data_in,
    output logic [8*BLOCK_BYTES-1:0]   rx_data,
    output logic                       rx_valid,
    output logic                       rx_busy,
    output logic                       irq_rx
);

    import spi8_pkg::*;

    localparam int         W         = SPI_LANES * BLOCK_BYTES;
    localparam logic [4:0] LAST_BYTE = 5'(BLOCK_BYTES - 1);

    rx_state_t                state;
    logic [4:0]               byte_cnt;
    logic [W-1:0]             shift;
    logic [SPI_LANES-1:0]     data_pipe [SYNC_STAGES];

    logic clk_level, clk_rise, clk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_sync;

    logic [SPI_LANES-1:0] cur_byte;
    logic [W-1:0]         next_shift;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_clk_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (spi_clk_in),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (spi_cs_n_in),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    assign unused_sync = &{1'b0, clk_level, clk_fall, cs_level};

    // Data lanes follow the same depth as the clock synchronizer so the byte
    // read on a detected rise is the one sampled alongside that clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) data_pipe[s] <= '0;
        end else begin
            data_pipe[0] <= spi_data_in;
            for (int s = 1; s < SYNC_STAGES; s++) data_pipe[s] <= data_pipe[s-1];
        end
    end

    assign cur_byte   = data_pipe[SYNC_STAGES-1];
    assign next_shift = {shift[W-SPI_LANES-1:0], cur_byte};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            byte_cnt <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_busy  <= 1'b0;
            irq_rx   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        irq_rx  <= 1'b0;
                        rx_busy <= 1'b1;
                        // A clock edge coinciding with the frame start is byte 0.
                        if (clk_rise) begin
                            shift    <= next_shift;
                            byte_cnt <= 5'd1;
                        end else begin
                            byte_cnt <= 5'd0;
                        end
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else if (clk_rise) begin
                        shift <= next_shift;
                        if (byte_cnt == LAST_BYTE) begin
                            rx_data  <= next_shift;
                            rx_valid <= 1'b1;
                            irq_rx   <= 1'b1;
                            state    <= DONE;
                        end
                        byte_cnt <= byte_cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_8lane.sv
// Scoreboard bench for spi_rx_8lane: frames push expected blocks, a monitor
// pops and compares on every rx_valid pulse.
module tb_spi_rx_8lane;

    localparam int SYNC = 2;

    logic         clk;
    logic         resetn;
    logic         spi_clk_in;
    logic         spi_cs_n_in;
    logic [7:0]   spi_data_in;
    logic [127:0] rx_data;
    logic         rx_valid;
    logic         rx_busy;
    logic         irq_rx;

    logic [127:0] expQ[$];
    int           assertCount = 0;
    int           failCount   = 0;
    int           pulseCount  = 0;
    int           expPulses   = 0;

    spi_rx_8lane #(.SYNC_STAGES(SYNC), .BLOCK_BYTES(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spi_clk_in  (spi_clk_in),
        .spi_cs_n_in (spi_cs_n_in),
        .spi_data_in (spi_data_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .irq_rx      (irq_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest outstanding block.
    always @(negedge clk) begin
        if (resetn && rx_valid) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_rx_valid: got data %h expected no pulse", rx_data);
            end else begin
                checkOutput("rx_data_block", rx_data, expQ.pop_front());
                checkOutput("irq_with_valid", 128'(irq_rx), 128'd1);
            end
        end
    end

    task automatic applyStimulus(input logic [127:0] blk, input int nbytes, input int half);
        int waited;
        bit seen;
        spi_cs_n_in = 1'b0;
        repeat (half) @(negedge clk);
        checkOutput("irq_clear_on_cs_fall", 128'(irq_rx), 128'd0);
        checkOutput("busy_at_start", 128'(rx_busy), 128'd1);
        if (nbytes >= 16) begin
            expQ.push_back(blk);
            expPulses++;
        end
        for (int i = 0; i < nbytes; i++) begin
            spi_data_in = (i < 16) ? blk[127-8*i -: 8] : 8'h11;
            repeat (half) @(negedge clk);
            spi_clk_in = 1'b1;
            if (i == 15) begin
                seen   = 1'b0;
                waited = 0;
                for (int k = 0; k < SYNC + 2; k++) begin
                    @(negedge clk);
                    waited++;
                    if (rx_valid) seen = 1'b1;
                end
                checkOutput("valid_latency", 128'(seen), 128'd1);
                for (int w = waited; w < half; w++) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            checkOutput("busy_in_frame", 128'(rx_busy), 128'd1);
            spi_clk_in = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_cs_n_in = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        checkOutput("busy_after_frame", 128'(rx_busy), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn      = 1'b0;
        spi_clk_in  = 1'b0;
        spi_cs_n_in = 1'b1;
        spi_data_in = 8'h00;
        repeat (5) @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 128'd0);
        checkOutput("reset_rx_valid", 128'(rx_valid), 128'd0);
        checkOutput("reset_rx_busy", 128'(rx_busy), 128'd0);
        checkOutput("reset_irq_rx", 128'(irq_rx), 128'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] ascending frame");
        applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 16, 8);
        checkOutput("irq_after_frame1", 128'(irq_rx), 128'd1);
        checkOutput("rx_data_frame1", rx_data, 128'h000102030405060708090a0b0c0d0e0f);

        $display("[TB] back-to-back frames");
        applyStimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16, 8);
        applyStimulus(128'hffeeddccbbaa99887766554433221100, 16, 8);
        checkOutput("rx_data_frame3", rx_data, 128'hffeeddccbbaa99887766554433221100);

        $display("[TB] short frame then full frame");
        applyStimulus(128'hdeadbeefcafebabe0123456789abcdef, 10, 8);
        checkOutput("rx_data_after_short", rx_data, 128'hffeeddccbbaa99887766554433221100);
        checkOutput("pulses_after_short", 128'(pulseCount), 128'd3);
        applyStimulus(128'hdeadbeefcafebabe0123456789abcdef, 16, 8);
        checkOutput("rx_data_after_full", rx_data, 128'hdeadbeefcafebabe0123456789abcdef);

        $display("[TB] over-length frame");
        applyStimulus({16{8'hA5}}, 20, 8);
        checkOutput("rx_data_overlength", rx_data, {16{8'hA5}});

        $display("[TB] spi_clk with cs_n high, then reset mid-frame");
        for (int i = 0; i < 4; i++) begin
            spi_data_in = 8'h55;
            repeat (8) @(negedge clk);
            spi_clk_in = 1'b1;
            repeat (8) @(negedge clk);
            spi_clk_in = 1'b0;
        end
        checkOutput("busy_cs_high", 128'(rx_busy), 128'd0);
        spi_cs_n_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            spi_data_in = 8'(8'h30 + i);
            repeat (8) @(negedge clk);
            spi_clk_in = 1'b1;
            repeat (8) @(negedge clk);
            spi_clk_in = 1'b0;
        end
        resetn = 1'b0;
        @(negedge clk);
        spi_cs_n_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_rx_data", rx_data, 128'd0);
        checkOutput("midreset_rx_valid", 128'(rx_valid), 128'd0);
        checkOutput("midreset_rx_busy", 128'(rx_busy), 128'd0);
        checkOutput("midreset_irq_rx", 128'(irq_rx), 128'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_reset_busy", 128'(rx_busy), 128'd0);

        $display("[TB] minimum timing frame");
        applyStimulus(128'h00112233445566778899aabbccddeeff, 16, SYNC + 1);
        checkOutput("rx_data_min_timing", rx_data, 128'h00112233445566778899aabbccddeeff);

        repeat (10) @(negedge clk);
        checkOutput("pulse_count", 128'(pulseCount), 128'(expPulses));
        checkOutput("queue_empty", 128'(expQ.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
